// File: rtl/move_pkg.sv
// move_pkg: shared types, slot encodings and op legality for move_seq.
// Build macro: MOVE_PARTIAL_EXT_EN enables the partial-width extension ops 3-6.
package move_pkg;

  typedef enum logic [2:0] {
    MV_MOVE    = 3'd0,
    MV_SWAP    = 3'd1,
    MV_SFILL   = 3'd2,
    MV_SEXT8   = 3'd3,
    MV_ZEXT8   = 3'd4,
    MV_SEXT16  = 3'd5,
    MV_ZEXT16  = 3'd6,
    MV_ILLEGAL = 3'd7
  } mv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2
  } mv_state_t;

  localparam logic MV_SLOT_DST = 1'b0;
  localparam logic MV_SLOT_SRC = 1'b1;

  // Extension ops only count as legal when their datapath is built in.
  function automatic logic mv_is_legal(input mv_op_t op);
`ifdef MOVE_PARTIAL_EXT_EN
    return (op != MV_ILLEGAL);
`else
    return (op == MV_MOVE) || (op == MV_SWAP) || (op == MV_SFILL);
`endif
  endfunction

endpackage

// File: rtl/move_ext.sv
// move_ext: combinational fill/extend datapath for ops 2-6.
// Build macro: MOVE_PARTIAL_EXT_EN adds the 8/16-bit sign/zero extenders;
// without it only the sign-fill path exists.
module move_ext
  import move_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  mv_op_t           op_i,
  input  logic [WIDTH-1:0] src_i,
  output logic [WIDTH-1:0] result_o
);

`ifdef MOVE_PARTIAL_EXT_EN
  // Select the fill or extension result; sign-fill doubles as the default.
  always_comb begin
    result_o = {WIDTH{src_i[WIDTH-1]}};
    case (op_i)
      MV_SEXT8:  result_o = {{(WIDTH-8){src_i[7]}}, src_i[7:0]};
      MV_ZEXT8:  result_o = {{(WIDTH-8){1'b0}}, src_i[7:0]};
      MV_SEXT16: result_o = {{(WIDTH-16){src_i[15]}}, src_i[15:0]};
      MV_ZEXT16: result_o = {{(WIDTH-16){1'b0}}, src_i[15:0]};
      default:   result_o = {WIDTH{src_i[WIDTH-1]}};
    endcase
  end
`else
  logic unusedExt;

  // Only sign-fill remains, so the op and low source bits are not needed.
  always_comb begin
    result_o  = {WIDTH{src_i[WIDTH-1]}};
    unusedExt = ^{op_i, src_i[WIDTH-2:0]};
  end
`endif

endmodule

// File: rtl/move_seq.sv
// move_seq: handshaked move/swap/sign-fill/extend unit emitting one
// registered write beat per destination operand.
// Build macro: MOVE_PARTIAL_EXT_EN enables ops 3-6 (otherwise illegal).
module move_seq
  import move_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  mv_op_t           in_op,
  input  logic [WIDTH-1:0] in_opnd0,
  input  logic [WIDTH-1:0] in_opnd1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_slot,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             op_err
);

  mv_state_t        state_q;
  logic [WIDTH-1:0] outData_q;
  logic             outSlot_q;
  logic             outLast_q;
  logic             opErr_q;
  logic [WIDTH-1:0] swapHold_q;

  logic [WIDTH-1:0] extResult;
  logic [WIDTH-1:0] firstData;
  logic             accept;
  logic             outFire;
  logic             opLegal;

  move_ext #(.WIDTH(WIDTH)) uExt (
    .op_i     (in_op),
    .src_i    (in_opnd1),
    .result_o (extResult)
  );

  // Handshake qualifiers; in_ready looks through out_ready so a final beat
  // and the next request can complete on the same edge with no bubble.
  always_comb begin
    outFire   = out_valid & out_ready;
    in_ready  = ~rst & ((state_q == ST_IDLE) | (out_valid & outLast_q & out_ready));
    accept    = in_valid & in_ready;
    opLegal   = mv_is_legal(in_op);
    firstData = ((in_op == MV_MOVE) || (in_op == MV_SWAP)) ? in_opnd1 : extResult;
  end

  // Beat FSM: captures operands on accept and advances on each handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      outData_q  <= '0;
      outSlot_q  <= MV_SLOT_DST;
      outLast_q  <= 1'b0;
      opErr_q    <= 1'b0;
      swapHold_q <= '0;
    end else begin
      opErr_q <= 1'b0;
      if (accept) begin
        if (opLegal) begin
          state_q    <= ST_BEAT0;
          outData_q  <= firstData;
          outSlot_q  <= MV_SLOT_DST;
          outLast_q  <= (in_op != MV_SWAP);
          swapHold_q <= in_opnd0;
        end else begin
          state_q <= ST_IDLE;
          opErr_q <= 1'b1;
        end
      end else if (outFire) begin
        if ((state_q == ST_BEAT0) && !outLast_q) begin
          state_q   <= ST_BEAT1;
          outData_q <= swapHold_q;
          outSlot_q <= MV_SLOT_SRC;
          outLast_q <= 1'b1;
        end else begin
          state_q <= ST_IDLE;
        end
      end
    end
  end

  // Outputs come straight from the registered FSM state.
  always_comb begin
    out_valid = (state_q != ST_IDLE);
    out_slot  = outSlot_q;
    out_data  = outData_q;
    out_last  = outLast_q;
    op_err    = opErr_q;
  end

endmodule

// File: tb/tb_move_seq.sv
// tb_move_seq: directed self-checking bench for move_seq.
// Build macro: MOVE_PARTIAL_EXT_EN selects the extension-op scenario.
module tb_move_seq;
  import move_pkg::*;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  mv_op_t           in_op;
  logic [WIDTH-1:0] in_opnd0;
  logic [WIDTH-1:0] in_opnd1;
  logic             out_valid;
  logic             out_ready;
  logic             out_slot;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             op_err;

  int checks   = 0;
  int failures = 0;

  move_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_opnd0  (in_opnd0),
    .in_opnd1  (in_opnd1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_slot  (out_slot),
    .out_data  (out_data),
    .out_last  (out_last),
    .op_err    (op_err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next rising edge: sample and drive here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks one beat's valid/slot/data/last against expected values.
  task automatic applyStimulus(input string name, input logic expValid, input logic expSlot,
                               input logic [WIDTH-1:0] expData, input logic expLast);
    checks++;
    if (out_valid !== expValid) begin
      failures++;
      $display("[TB] FAIL %s_valid got=%b exp=%b", name, out_valid, expValid);
    end
    if (expValid) begin
      checks++;
      if ({out_slot, out_last, out_data} !== {expSlot, expLast, expData}) begin
        failures++;
        $display("[TB] FAIL %s_beat got slot=%b last=%b data=%h exp slot=%b last=%b data=%h",
                 name, out_slot, out_last, out_data, expSlot, expLast, expData);
      end
    end
  endtask

  // Reset with in_valid high: nothing accepted, all outputs at reset values.
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_op = MV_MOVE;
    in_opnd0 = 32'h5555_5555; in_opnd1 = 32'h6666_6666; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_hold got ready=%b valid=%b exp ready=0 valid=0", in_ready, out_valid);
      end
    end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    checks++;
    if ({out_valid, out_slot, out_last, op_err, out_data} !== {4'b0000, 32'h0}) begin
      failures++;
      $display("[TB] FAIL reset_values got v=%b s=%b l=%b e=%b d=%h exp all zero",
               out_valid, out_slot, out_last, op_err, out_data);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_ready got=%b exp=1", in_ready);
    end
  endtask

  // Plain move; operands changed after accept must not affect the beat.
  task automatic test_move();
    in_valid = 1'b1; in_op = MV_MOVE; out_ready = 1'b1;
    in_opnd0 = 32'h1111_1111; in_opnd1 = 32'h8000_0001;
    tick();
    in_valid = 1'b0; in_opnd0 = 32'hDEAD_BEEF; in_opnd1 = 32'hCAFE_F00D;
    applyStimulus("move", 1'b1, 1'b0, 32'h8000_0001, 1'b1);
    tick();
    applyStimulus("move_done", 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Swap stalled three cycles on beat0, then both beats drain.
  task automatic test_swap();
    in_valid = 1'b1; in_op = MV_SWAP; out_ready = 1'b0;
    in_opnd0 = 32'hAAAA_0000; in_opnd1 = 32'h0000_BBBB;
    tick();
    in_valid = 1'b0; in_opnd0 = 32'h0; in_opnd1 = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      applyStimulus("swap_stall", 1'b1, 1'b0, 32'h0000_BBBB, 1'b0);
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL swap_stall_ready got=%b exp=0", in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    applyStimulus("swap_beat0", 1'b1, 1'b0, 32'h0000_BBBB, 1'b0);
    tick();
    applyStimulus("swap_beat1", 1'b1, 1'b1, 32'hAAAA_0000, 1'b1);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL swap_last_ready got=%b exp=1", in_ready);
    end
    tick();
    applyStimulus("swap_done", 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Two sign-fills back to back with no bubble between beats.
  task automatic test_back_to_back();
    in_valid = 1'b1; in_op = MV_SFILL; out_ready = 1'b1;
    in_opnd0 = 32'h0; in_opnd1 = 32'h8000_0000;
    tick();
    in_opnd1 = 32'h7FFF_FFFF;
    #1;
    applyStimulus("sfill_a", 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_ready got=%b exp=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    applyStimulus("sfill_b", 1'b1, 1'b0, 32'h0000_0000, 1'b1);
    tick();
    applyStimulus("sfill_done", 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Illegal op: accepted, no beat, one-cycle op_err.
  task automatic test_illegal(input mv_op_t op);
    in_valid = 1'b1; in_op = op; out_ready = 1'b1;
    in_opnd0 = 32'h1234_5678; in_opnd1 = 32'h1234_F080;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL illegal_accept op=%0d got=%b exp=1", op, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({op_err, out_valid} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL illegal_err op=%0d got err=%b valid=%b exp err=1 valid=0", op, op_err, out_valid);
    end
    tick();
    checks++;
    if ({op_err, out_valid, in_ready} !== 3'b001) begin
      failures++;
      $display("[TB] FAIL illegal_after op=%0d got err=%b valid=%b ready=%b exp 0 0 1",
               op, op_err, out_valid, in_ready);
    end
  endtask

`ifdef MOVE_PARTIAL_EXT_EN
  // Partial-width sign/zero extensions of 0x1234F080.
  task automatic test_ext();
    mv_op_t           ops  [4] = '{MV_SEXT8, MV_ZEXT8, MV_SEXT16, MV_ZEXT16};
    logic [WIDTH-1:0] exps [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_F080, 32'h0000_F080};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_op = ops[i]; out_ready = 1'b1;
      in_opnd0 = 32'h0; in_opnd1 = 32'h1234_F080;
      tick();
      in_valid = 1'b0;
      applyStimulus($sformatf("ext_op%0d", ops[i]), 1'b1, 1'b0, exps[i], 1'b1);
      checks++;
      if (op_err !== 1'b0) begin
        failures++;
        $display("[TB] FAIL ext_err op=%0d got=%b exp=0", ops[i], op_err);
      end
      tick();
    end
  endtask
`endif

  // Reset while a swap holds its second beat drops it for good.
  task automatic test_reset_mid();
    in_valid = 1'b1; in_op = MV_SWAP; out_ready = 1'b1;
    in_opnd0 = 32'h0102_0304; in_opnd1 = 32'h0506_0708;
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    applyStimulus("mid_beat1", 1'b1, 1'b1, 32'h0102_0304, 1'b1);
    rst = 1'b1;
    tick();
    applyStimulus("mid_reset", 1'b0, 1'b0, 32'h0, 1'b0);
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        failures++;
        $display("[TB] FAIL mid_after got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
      end
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_move();
    test_swap();
    test_back_to_back();
`ifdef MOVE_PARTIAL_EXT_EN
    test_ext();
`else
    test_illegal(MV_SEXT8);
    test_illegal(MV_ZEXT16);
`endif
    test_illegal(MV_ILLEGAL);
    test_move();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/move_seq.md
# move_seq

Parametrised, handshaked successor to the combinational move/swap/sign-fill unit in the tiny86 execute stage. It accepts one operand pair per transaction and applies the selected move-class operation: move, swap, sign-fill, or partial-width sign/zero extension. Results leave as a sequence of registered single-operand write beats, one beat per destination operand, over a ready/valid channel. It sits between execute-stage operand fetch and the register/memory write-back arbiter.

## Interface
Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of 8 and at least 16.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted this cycle when in_valid is also high.
- in_op  in  3  operation code (move_pkg::mv_op_t).
- in_opnd0  in  WIDTH  operand 0 (DST).
- in_opnd1  in  WIDTH  operand 1 (SRC).
- out_valid  out  1  write beat present.
- out_ready  in  1  beat consumed this cycle when out_valid is also high.
- out_slot  out  1  destination slot of the beat: 0 = opnd0, 1 = opnd1.
- out_data  out  WIDTH  value to write.
- out_last  out  1  final beat of the transaction.
- op_err  out  1  one-cycle pulse: an illegal op was accepted.

## Operation
- Opcodes:
  - MV_MOVE=0: one beat, slot0 = opnd1.
  - MV_SWAP=1: two beats, slot0 = opnd1, then slot1 = opnd0.
  - MV_SFILL=2: one beat, slot0 = {WIDTH{opnd1[WIDTH-1]}}.
  - MV_SEXT8=3: one beat, slot0 = opnd1[7:0] sign-extended to WIDTH.
  - MV_ZEXT8=4: one beat, slot0 = opnd1[7:0] zero-extended to WIDTH.
  - MV_SEXT16=5: one beat, slot0 = opnd1[15:0] sign-extended to WIDTH.
  - MV_ZEXT16=6: one beat, slot0 = opnd1[15:0] zero-extended to WIDTH.
  - 7: illegal.
- Both operands are captured at acceptance. Later changes on the in_* ports have no effect on the transaction.
- Illegal op: the request is accepted, no beat is emitted, and op_err pulses high for the cycle after acceptance.
- FSM states:
  - IDLE: no beat held.
  - BEAT0: first/only beat valid.
  - BEAT1: swap second beat valid.
- FSM transitions:
  - IDLE → BEAT0 on a legal accept.
  - IDLE stays in IDLE on an illegal accept.
  - BEAT0 → BEAT1 on a swap handshake.
  - BEAT0 (non-swap) → IDLE, or → BEAT0 on back-to-back accept.
  - BEAT1 → IDLE, or → BEAT0 on back-to-back accept.
- in_ready = (state==IDLE) | (out_valid & out_last & out_ready). This is a combinational path from out_ready and is intentional. It gives full throughput with no bubble.
- out_last is high in BEAT0 for non-swap ops and in BEAT1 for swap.
- Reset values: state=IDLE, out_valid=0, out_slot=0, out_last=0, out_data=0, op_err=0. in_ready is 1 one cycle after reset deasserts.
- Reset mid-transaction drops any pending beat; no further beats of that transaction appear.

## Timing
- Latency: a request accepted at edge N makes its first beat valid in the cycle after N.
- A swap stalled by out_ready=0 holds out_data, out_slot and out_last stable.
- out_valid never drops without a handshake.
- Throughput: one single-beat op per cycle; a swap occupies two cycles.
- in_valid=1 while rst=1 is ignored; in_ready is 0 during reset.

## Configuration
- MOVE_PARTIAL_EXT_EN defined: ops 3–6 behave as specified above.
- MOVE_PARTIAL_EXT_EN undefined: ops 3–6 are treated as illegal (accepted, no beat, op_err pulse), and the extension datapath is removed.
- Ops 0–2 are identical in both builds.

## Structure
- move_pkg holds:
  - mv_op_t, a 3-bit enum with the encodings above.
  - MV_SLOT_DST=0 and MV_SLOT_SRC=1.
  - Function mv_is_legal(op), which respects MOVE_PARTIAL_EXT_EN.
- One sub-module, move_ext: a combinational WIDTH-parametrised fill/extend datapath for ops 2–6, instantiated once. move_seq owns the FSM and the beat registers.

## Test plan
- MV_MOVE, opnd0=0x11111111, opnd1=0x80000001, out_ready=1 → one beat: slot0, data 0x80000001, last=1, in the cycle after accept.
- MV_SWAP, opnd0=0xAAAA0000, opnd1=0x0000BBBB, out_ready held 0 for 3 cycles then 1 → beat0 stable (slot0, 0x0000BBBB, last=0), then beat1 (slot1, 0xAAAA0000, last=1).
- MV_SFILL with opnd1=0x80000000, then 0x7FFFFFFF, back-to-back → 0xFFFFFFFF then 0x00000000 on consecutive cycles, no bubble.
- With MOVE_PARTIAL_EXT_EN, opnd1=0x1234F080:
  - SEXT8 → 0xFFFFFF80
  - ZEXT8 → 0x00000080
  - SEXT16 → 0xFFFFF080
  - ZEXT16 → 0x0000F080
- Without MOVE_PARTIAL_EXT_EN, op 3 → accepted, no beat, op_err=1 for exactly one cycle. Op 7 behaves the same in both builds.
- rst asserted while a swap sits in BEAT1 → out_valid=0 in the next cycle, IDLE, and no stale beat after deassert.
